// File: rtl/fm_receiver_mul_pkg.sv
// Shared defaults and Q15 constants for the FM receiver shared-multiplier arbiter.
// The optional Q15 output stage is enabled with FM_MUL_ARB_Q15_EN.
package fm_receiver_mul_pkg;

   localparam int NREQ_DEF    = 4;
   localparam int AW_DEF      = 16;
   localparam int BW_DEF      = 16;
   localparam int PW_DEF      = 32;
   localparam int MUL_LAT_DEF = 3;

   // Q15 round-half-up and saturation to the 16-bit signed range
   localparam int Q15_RND   = 1 << 14;
   localparam int Q15_SHIFT = 15;
   localparam int Q15_MAX   = 32767;
   localparam int Q15_MIN   = -32768;

endpackage

// File: rtl/fm_receiver_mul_arbiter_if.sv
// Requester/result bus of the shared multiplier: per-requester valid/ready operands in,
// in-order tagged products out.
interface fm_receiver_mul_arbiter_if
   import fm_receiver_mul_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF,
   parameter int BW   = BW_DEF,
   parameter int PW   = PW_DEF
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*AW-1:0] req_a;
   logic [NREQ*BW-1:0] req_b;
   logic               res_valid;
   logic [IDW-1:0]     res_id;
   logic signed [PW-1:0] res_data;

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, res_valid, res_id, res_data
   );

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, res_valid, res_id, res_data
   );

endinterface

// File: rtl/fm_receiver_mul_rr_arb.sv
// Round-robin arbiter: one-hot grant searched cyclically from ptr; ptr moves past the
// granted requester whenever the grant is actually taken (advance).
module fm_receiver_mul_rr_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  gnt_id
);

   logic [IDW-1:0] ptr;

   always_comb begin
      int  idx;
      logic found;
      grant  = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            gnt_id     = IDW'(idx);
            found      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
      end
   end

endmodule

// File: rtl/fm_receiver_mul_arbiter.sv
// Shared pipelined signed multiplier with round-robin operand arbitration and in-order,
// id-tagged results. Define FM_MUL_ARB_Q15_EN for a Q15 round/saturate output stage.
module fm_receiver_mul_arbiter
   import fm_receiver_mul_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int AW      = AW_DEF,
   parameter int BW      = BW_DEF,
   parameter int PW      = PW_DEF,
   parameter int MUL_LAT = MUL_LAT_DEF
) (
   input  logic ap_clk,
   input  logic ap_rst_n,
   input  logic ce,
   output logic busy,
   fm_receiver_mul_arbiter_if.slave bus
);

   localparam int IDW = $clog2(NREQ);
   localparam int PRW = AW + BW;
`ifdef FM_MUL_ARB_Q15_EN
   localparam int NST = MUL_LAT + 1;
`else
   localparam int NST = MUL_LAT;
`endif

`ifdef FM_MUL_ARB_Q15_EN
   function automatic logic signed [PRW-1:0] q15_round_sat(input logic signed [PRW-1:0] p);
      logic signed [PRW:0] t;
      t = ((PRW+1)'(p) + (PRW+1)'(Q15_RND)) >>> Q15_SHIFT;
      if (t > (PRW+1)'(Q15_MAX)) return PRW'(Q15_MAX);
      if (t < (PRW+1)'(Q15_MIN)) return PRW'(Q15_MIN);
      return PRW'(t);
   endfunction
`endif

   logic [NREQ-1:0]       grant;
   logic [IDW-1:0]        gnt_id;
   logic                  xfer;
   logic signed [AW-1:0]  a_sel;
   logic signed [BW-1:0]  b_sel;
   logic signed [PRW-1:0] a_ext;
   logic signed [PRW-1:0] b_ext;
   logic signed [PRW-1:0] prod_p0;

   logic [NST:1]          vld_p;
   logic [IDW-1:0]        id_p  [1:NST];
   logic signed [PRW-1:0] dat_p [1:NST];

   // Reset also forces ready low so nothing is accepted while the pipeline is cleared
   assign bus.req_ready = grant & {NREQ{ce & ap_rst_n}};
   assign xfer          = |bus.req_ready;

   fm_receiver_mul_rr_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .clk     (ap_clk),
      .rst_n   (ap_rst_n),
      .req     (bus.req_valid),
      .advance (xfer),
      .grant   (grant),
      .gnt_id  (gnt_id)
   );

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            a_sel = bus.req_a[i*AW +: AW];
            b_sel = bus.req_b[i*BW +: BW];
         end
      end
   end

   assign a_ext   = PRW'(a_sel);
   assign b_ext   = PRW'(b_sel);
   assign prod_p0 = a_ext * b_ext;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         vld_p <= '0;
         for (int s = 1; s <= NST; s++) begin
            id_p[s]  <= '0;
            dat_p[s] <= '0;
         end
      end else if (ce) begin
         // stage 1: granted operand product enters the pipeline
         vld_p[1] <= xfer;
         id_p[1]  <= gnt_id;
         dat_p[1] <= prod_p0;
         // stages 2..MUL_LAT: product delay line
         for (int s = 2; s <= MUL_LAT; s++) begin
            vld_p[s] <= vld_p[s-1];
            id_p[s]  <= id_p[s-1];
            dat_p[s] <= dat_p[s-1];
         end
`ifdef FM_MUL_ARB_Q15_EN
         // final stage: Q15 round and saturate
         vld_p[NST] <= vld_p[MUL_LAT];
         id_p[NST]  <= id_p[MUL_LAT];
         dat_p[NST] <= q15_round_sat(dat_p[MUL_LAT]);
`endif
      end
   end

   assign bus.res_valid = vld_p[NST] & ce;
   assign bus.res_id    = id_p[NST];
   assign bus.res_data  = PW'(dat_p[NST]);
   assign busy          = |vld_p;

endmodule

// File: tb/tb_fm_receiver_mul_arbiter.sv
// Randomized bench for fm_receiver_mul_arbiter with an in-bench arbitration/result model.
// Honours FM_MUL_ARB_Q15_EN the same way as the design.
module tb_fm_receiver_mul_arbiter;

   localparam int NREQ    = 4;
   localparam int AW      = 16;
   localparam int BW      = 16;
   localparam int PW      = 32;
   localparam int MUL_LAT = 3;
`ifdef FM_MUL_ARB_Q15_EN
   localparam int LAT = MUL_LAT + 1;
`else
   localparam int LAT = MUL_LAT;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic ce;
   logic busy;

   always #5 clk = ~clk;

   fm_receiver_mul_arbiter_if #(.NREQ(NREQ), .AW(AW), .BW(BW), .PW(PW)) bus ();

   fm_receiver_mul_arbiter #(
      .NREQ(NREQ), .AW(AW), .BW(BW), .PW(PW), .MUL_LAT(MUL_LAT)
   ) dut (
      .ap_clk   (clk),
      .ap_rst_n (rst_n),
      .ce       (ce),
      .busy     (busy),
      .bus      (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Expected result value from the arithmetic rules
   function automatic longint expect_val(input longint a, input longint b);
      longint p;
      p = a * b;
`ifdef FM_MUL_ARB_Q15_EN
      p = (p + 16384) >>> 15;
      if (p > 32767) p = 32767;
      if (p < -32768) p = -32768;
`endif
      return p;
   endfunction

   // ---------------- behavioural model + per-cycle compare ----------------
   typedef struct {
      int     id;
      longint data;
      int     age;
   } ent_t;

   ent_t   m_q[$];
   int     m_ptr = 0;
   int     m_g;
   int     m_idx;
   logic   m_due;
   longint m_rdy;
   ent_t   m_new;
   logic signed [AW-1:0] m_a;
   logic signed [BW-1:0] m_b;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_q.delete();
         m_ptr = 0;
         check("rst_ready", longint'(bus.req_ready), 0);
         check("rst_res_valid", longint'(bus.res_valid), 0);
         check("rst_busy", longint'(busy), 0);
      end else begin
         m_g = -1;
         for (int k = 0; k < NREQ; k++) begin
            m_idx = (m_ptr + k) % NREQ;
            if (m_g < 0 && bus.req_valid[m_idx]) m_g = m_idx;
         end
         m_rdy = (ce && m_g >= 0) ? (longint'(1) << m_g) : 0;
         m_due = (m_q.size() > 0) && (m_q[0].age == LAT);
         check("m_ready", longint'(bus.req_ready), m_rdy);
         check("m_res_valid", longint'(bus.res_valid), longint'(ce && m_due));
         check("m_busy", longint'(busy), longint'(m_q.size() > 0));
         if (m_due) begin
            check("m_res_id", longint'(bus.res_id), longint'(m_q[0].id));
            check("m_res_data", longint'(bus.res_data), m_q[0].data);
         end
         if (ce) begin
            if (m_due) void'(m_q.pop_front());
            foreach (m_q[i]) m_q[i].age++;
            if (m_g >= 0) begin
               m_a = bus.req_a[m_g*AW +: AW];
               m_b = bus.req_b[m_g*BW +: BW];
               m_new.id   = m_g;
               m_new.data = expect_val(longint'(m_a), longint'(m_b));
               m_new.age  = 1;
               m_q.push_back(m_new);
               m_ptr = (m_g + 1) % NREQ;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input int a, input int b);
      bus.req_a[i*AW +: AW] = AW'(a);
      bus.req_b[i*BW +: BW] = BW'(b);
   endtask

   function automatic int rnd_op();
      case ($urandom % 8)
         0:       return -32768;
         1:       return 32767;
         default: return int'($urandom % 65536) - 32768;
      endcase
   endfunction

   task automatic rnd_all_ops();
      for (int i = 0; i < NREQ; i++) set_op(i, rnd_op(), rnd_op());
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      longint exp_v;
      rst_n         = 1'b0;
      ce            = 1'b1;
      bus.req_valid = '1;
      bus.req_a     = '0;
      bus.req_b     = '0;
      repeat (3) tick();
      #1;
      check("reset_res_valid", longint'(bus.res_valid), 0);
      check("reset_res_id", longint'(bus.res_id), 0);
      check("reset_res_data", longint'(bus.res_data), 0);
      check("reset_busy", longint'(busy), 0);
      check("reset_ready", longint'(bus.req_ready), 0);
      tick();
      rst_n         = 1'b1;
      bus.req_valid = '0;
      tick();

      // single transfer, 3 * -5
      set_op(0, 3, -5);
      bus.req_valid = 4'b0001;
      #1 check("t1_ready", longint'(bus.req_ready), 1);
      tick();
      bus.req_valid = '0;
      repeat (LAT - 1) tick();
      #1;
`ifdef FM_MUL_ARB_Q15_EN
      exp_v = 0;
`else
      exp_v = -15;
`endif
      check("t1_valid", longint'(bus.res_valid), 1);
      check("t1_id", longint'(bus.res_id), 0);
      check("t1_data", longint'(bus.res_data), exp_v);
      tick();

      // all requesters valid from ptr=0
      do_reset();
      for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 2);
      bus.req_valid = '1;
      for (int c = 0; c < 12; c++) begin
         if (c == 8) bus.req_valid = '0;
         #1;
         if (c < 8) check("t2_grant", longint'(bus.req_ready), longint'(1) << (c % 4));
         if (c >= LAT && c - LAT < 8) begin
`ifdef FM_MUL_ARB_Q15_EN
            exp_v = 0;
`else
            exp_v = 2 * ((c - LAT) % 4 + 1);
`endif
            check("t2_valid", longint'(bus.res_valid), 1);
            check("t2_id", longint'(bus.res_id), (c - LAT) % 4);
            check("t2_data", longint'(bus.res_data), exp_v);
         end
         tick();
      end

      // most-negative operands
      set_op(1, -32768, -32768);
      bus.req_valid = 4'b0010;
      tick();
      bus.req_valid = '0;
      repeat (LAT - 1) tick();
      #1;
`ifdef FM_MUL_ARB_Q15_EN
      exp_v = 32767;
`else
      exp_v = 64'h4000_0000;
`endif
      check("t3_valid", longint'(bus.res_valid), 1);
      check("t3_id", longint'(bus.res_id), 1);
      check("t3_data", longint'(bus.res_data), exp_v);
      tick();

      // full pipeline frozen by ce=0
      bus.req_valid = '1;
      for (int c = 0; c < 6; c++) begin
         rnd_all_ops();
         tick();
      end
      ce = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("t4_ready", longint'(bus.req_ready), 0);
         check("t4_res_valid", longint'(bus.res_valid), 0);
         tick();
      end
      ce            = 1'b1;
      bus.req_valid = '0;
      repeat (LAT + 3) tick();

      // lone requester 2, then requester 0 joins
      bus.req_valid = 4'b0100;
      for (int c = 0; c < 10; c++) begin
         rnd_all_ops();
         #1 check("t5_solo", longint'(bus.req_ready), 4);
         tick();
      end
      bus.req_valid = 4'b0101;
      for (int c = 0; c < 4; c++) begin
         rnd_all_ops();
         #1 check("t5_rotate", longint'(bus.req_ready), (c % 2 == 0) ? 1 : 4);
         tick();
      end
      bus.req_valid = '0;
      repeat (LAT + 2) tick();

      // asynchronous reset with operations in flight
      bus.req_valid = '1;
      repeat (4) begin
         rnd_all_ops();
         tick();
      end
      check("t6_busy_before", longint'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("t6_res_valid", longint'(bus.res_valid), 0);
      check("t6_busy", longint'(busy), 0);
      check("t6_ready", longint'(bus.req_ready), 0);
      tick();
      tick();
      rst_n         = 1'b1;
      bus.req_valid = '0;
      for (int c = 0; c < LAT + 2; c++) begin
         #1 check("t6_no_stale", longint'(bus.res_valid), 0);
         tick();
      end

      // randomized traffic, ce gaps and occasional resets
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rnd_all_ops();
         bus.req_valid = NREQ'($urandom);
         ce            = ($urandom % 8) != 0;
         if (cyc % 700 == 350) rst_n = 1'b0;
         else                  rst_n = 1'b1;
         tick();
      end
      rst_n         = 1'b1;
      ce            = 1'b1;
      bus.req_valid = '0;
      repeat (LAT + 3) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
